// File: rtl/vga_disp_pkg.sv
// Shared definitions for the VGA single-digit display arbiter.
// Holds the FSM state encoding, the source ids, the default hold time,
// the digit width and the round-robin source pick used at grant time.
package vga_disp_pkg;

    localparam int DIGIT_W         = 4;
    localparam int HOLD_FRAMES_DEF = 60;   // ~1 s at 1024x768@60

    localparam logic SRC_CPU = 1'b0;       // config-register path
    localparam logic SRC_SW  = 1'b1;       // board debug switches

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    // Pick a source among the full slots. With both full the one that
    // did not win last time goes next.
    function automatic logic rr_pick(input logic full0, input logic full1,
                                     input logic last_grant);
        if (full0 && full1) return ~last_grant;
        else if (full1)     return SRC_SW;
        else                return SRC_CPU;
    endfunction

endpackage

// File: rtl/vga_req_slot.sv
// One-deep request slot with req/ack capture.
// Ports:
//   clk_vga, rstn   clock, async active-low reset
//   req, data       requester side; data held stable while req is high
//   ack             one-cycle pulse on the capture edge
//   clr             arbiter consumed the slot on this edge
//   full, slot_data stored digit and its valid flag
module vga_req_slot
    import vga_disp_pkg::*;
(
    input  logic               clk_vga,
    input  logic               rstn,
    input  logic               req,
    input  logic [DIGIT_W-1:0] data,
    input  logic               clr,
    output logic               ack,
    output logic               full,
    output logic [DIGIT_W-1:0] slot_data
);

    logic               ack_q,  ack_d;
    logic               full_q, full_d;
    logic [DIGIT_W-1:0] data_q, data_d;

    // Capture looks at the registered full flag, so a slot being cleared
    // on this edge still refuses a new request until the following edge.
    // clr is only raised while full_q is set, so it never collides with a
    // capture.
    always_comb begin
        ack_d  = 1'b0;
        full_d = full_q;
        data_d = data_q;
        if (clr) full_d = 1'b0;
        // !ack_q keeps a req still high in the ack cycle from recapturing.
        if (req && !ack_q && !full_q) begin
            data_d = data;
            full_d = 1'b1;
            ack_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_vga or negedge rstn) begin
        if (!rstn) begin
            ack_q  <= 1'b0;
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= ack_d;
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ack       = ack_q;
    assign full      = full_q;
    assign slot_data = data_q;

endmodule

// File: rtl/vga_disp_arb.sv
// Arbitrates the single-digit VGA display between the CPU config path
// (src 0) and the debug switch path (src 1). Requests land in 1-deep
// slots; at a frame boundary one full slot is granted round-robin and
// pushed to the renderer with a one-cycle strobe, then the digit is held
// for HOLD_FRAMES frames before another grant.
// Ports:
//   clk_vga, rstn          pixel clock, async active-low reset
//   frame_tick             one-cycle frame start pulse
//   req0/data0/ack0        src 0 handshake
//   req1/data1/ack1        src 1 handshake
//   num, confreg_en        digit and update strobe to the renderer
//   cur_src                source of the digit on screen
//   busy                   FSM in EMIT or HOLD
module vga_disp_arb
    import vga_disp_pkg::*;
#(
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic               clk_vga,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic               req0,
    input  logic [DIGIT_W-1:0] data0,
    output logic               ack0,
    input  logic               req1,
    input  logic [DIGIT_W-1:0] data1,
    output logic               ack1,
    output logic [DIGIT_W-1:0] num,
    output logic               confreg_en,
    output logic               cur_src,
    output logic               busy
);

    if (HOLD_FRAMES < 0 || HOLD_FRAMES >= (1 << CNT_W)) begin : g_bad_hold
        $error("vga_disp_arb: HOLD_FRAMES must be in [0, 2^CNT_W)");
    end

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_FRAMES);

    logic               full0, full1;
    logic [DIGIT_W-1:0] slot0, slot1;
    logic               clr0, clr1;
    logic               sel;

    vga_req_slot u_slot0 (
        .clk_vga   (clk_vga),
        .rstn      (rstn),
        .req       (req0),
        .data      (data0),
        .clr       (clr0),
        .ack       (ack0),
        .full      (full0),
        .slot_data (slot0)
    );

    vga_req_slot u_slot1 (
        .clk_vga   (clk_vga),
        .rstn      (rstn),
        .req       (req1),
        .data      (data1),
        .clr       (clr1),
        .ack       (ack1),
        .full      (full1),
        .slot_data (slot1)
    );

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [DIGIT_W-1:0] num_q, num_d;
    logic               confreg_en_q, confreg_en_d;
    logic               cur_src_q, cur_src_d;
    logic               busy_q, busy_d;

    assign sel = rr_pick(full0, full1, last_grant_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        num_d        = num_q;
        cur_src_d    = cur_src_q;
        confreg_en_d = 1'b0;
        clr0         = 1'b0;
        clr1         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick && (full0 || full1)) begin
                    num_d        = sel ? slot1 : slot0;
                    cur_src_d    = sel;
                    last_grant_d = sel;
                    clr0         = (sel == SRC_CPU);
                    clr1         = (sel == SRC_SW);
                    confreg_en_d = 1'b1;
                    state_d      = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // A frame_tick landing here is deliberately dropped.
                if (HOLD_FRAMES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = HOLD_CNT;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The tick that expires the hold only returns to IDLE; the
                // next grant needs a fresh tick.
                if (frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_vga or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= SRC_SW;   // so src 0 wins the first tie
            num_q        <= '0;
            confreg_en_q <= 1'b0;
            cur_src_q    <= SRC_CPU;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            num_q        <= num_d;
            confreg_en_q <= confreg_en_d;
            cur_src_q    <= cur_src_d;
            busy_q       <= busy_d;
        end
    end

    assign num        = num_q;
    assign confreg_en = confreg_en_q;
    assign cur_src    = cur_src_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vga_disp_arb.sv
module tb_vga_disp_arb;

    logic       clk_vga = 1'b0;
    logic       rstn;
    logic       frame_tick;
    logic       req0, req1;
    logic [3:0] data0, data1;

    // DUT with a 3-frame hold
    logic       ack0, ack1, confreg_en, cur_src, busy;
    logic [3:0] num;
    // DUT with hold disabled, same stimulus
    logic       z_ack0, z_ack1, z_en, z_src, z_busy;
    logic [3:0] z_num;

    int checks = 0;
    int errors = 0;

    always #5 clk_vga = ~clk_vga;

    vga_disp_arb #(.HOLD_FRAMES(3), .CNT_W(8)) u_dut (
        .clk_vga(clk_vga), .rstn(rstn), .frame_tick(frame_tick),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .num(num), .confreg_en(confreg_en), .cur_src(cur_src), .busy(busy)
    );

    vga_disp_arb #(.HOLD_FRAMES(0), .CNT_W(8)) u_dut0 (
        .clk_vga(clk_vga), .rstn(rstn), .frame_tick(frame_tick),
        .req0(req0), .data0(data0), .ack0(z_ack0),
        .req1(req1), .data1(data1), .ack1(z_ack1),
        .num(z_num), .confreg_en(z_en), .cur_src(z_src), .busy(z_busy)
    );

    typedef struct {
        logic       rst;
        logic       r0;
        logic [3:0] d0;
        logic       r1;
        logic [3:0] d1;
        logic       tick;
        logic [3:0] e_num;
        logic       e_en, e_a0, e_a1, e_src, e_busy;
    } vec_t;

    vec_t tv[27];

    function automatic vec_t mk(input logic rst, r0, input logic [3:0] d0,
                                input logic r1, input logic [3:0] d1,
                                input logic tick, input logic [3:0] e_num,
                                input logic e_en, e_a0, e_a1, e_src, e_busy);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.tick = tick;
        v.e_num = e_num; v.e_en = e_en; v.e_a0 = e_a0; v.e_a1 = e_a1;
        v.e_src = e_src; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic rst_pulse();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    // {num, confreg_en, ack0, ack1, cur_src, busy} of the HOLD=3 DUT
    function automatic logic [15:0] outs3();
        return {7'd0, num, confreg_en, ack0, ack1, cur_src, busy};
    endfunction

    function automatic logic [15:0] outs0();
        return {7'd0, z_num, z_en, z_ack0, z_ack1, z_src, z_busy};
    endfunction

    initial begin
        rstn = 1'b0; frame_tick = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 4'h0; data1 = 4'h0;

        //            rst r0 d0    r1 d1    tk  num   en a0 a1 src busy
        tv[0]  = mk(0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 4'h7, 0, 4'h0, 0, 4'h0, 0, 1, 0, 0, 0);
        tv[2]  = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h7, 1, 0, 0, 0, 1);
        tv[3]  = mk(0, 0, 4'h0, 0, 4'h0, 0, 4'h7, 0, 0, 0, 0, 1);
        tv[4]  = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 0, 1);
        tv[5]  = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 0, 1);
        tv[6]  = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 0, 0);
        tv[7]  = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 0, 0);
        tv[8]  = mk(1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        tv[9]  = mk(0, 1, 4'h2, 1, 4'h9, 0, 4'h0, 0, 1, 1, 0, 0);
        tv[10] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h2, 1, 0, 0, 0, 1);
        tv[11] = mk(0, 0, 4'h0, 0, 4'h0, 0, 4'h2, 0, 0, 0, 0, 1);
        tv[12] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h2, 0, 0, 0, 0, 1);
        tv[13] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h2, 0, 0, 0, 0, 1);
        tv[14] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h2, 0, 0, 0, 0, 0);
        tv[15] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h9, 1, 0, 0, 1, 1);
        tv[16] = mk(0, 1, 4'h4, 1, 4'h5, 0, 4'h9, 0, 1, 1, 1, 1);
        tv[17] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h9, 0, 0, 0, 1, 1);
        tv[18] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h9, 0, 0, 0, 1, 1);
        tv[19] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h9, 0, 0, 0, 1, 0);
        tv[20] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h4, 1, 0, 0, 0, 1);
        tv[21] = mk(0, 1, 4'h6, 0, 4'h0, 0, 4'h4, 0, 1, 0, 0, 1);
        tv[22] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h4, 0, 0, 0, 0, 1);
        tv[23] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h4, 0, 0, 0, 0, 1);
        tv[24] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h4, 0, 0, 0, 0, 0);
        tv[25] = mk(0, 0, 4'h0, 0, 4'h0, 1, 4'h5, 1, 0, 0, 1, 1);
        tv[26] = mk(0, 0, 4'h0, 0, 4'h0, 0, 4'h5, 0, 0, 0, 1, 1);

        #2;
        chk("reset_state", outs3(), 16'h0);
        cyc();
        rstn = 1'b1;

        // grant, hold, round-robin
        for (int i = 0; i < 27; i++) begin
            rstn = ~tv[i].rst;
            req0 = tv[i].r0; data0 = tv[i].d0;
            req1 = tv[i].r1; data1 = tv[i].d1;
            frame_tick = tv[i].tick;
            cyc();
            chk($sformatf("vec%0d", i), outs3(),
                {7'd0, tv[i].e_num, tv[i].e_en, tv[i].e_a0, tv[i].e_a1,
                 tv[i].e_src, tv[i].e_busy});
        end
        req0 = 1'b0; req1 = 1'b0; frame_tick = 1'b0; rstn = 1'b1;

        // slot full: req1 held while slot1 is occupied
        rst_pulse();
        req1 = 1'b1; data1 = 4'h3;
        cyc();
        chk("full_first_ack", {15'd0, ack1}, 16'd1);
        req1 = 1'b0;
        cyc();
        chk("full_ack_pulse", {15'd0, ack1}, 16'd0);
        req1 = 1'b1; data1 = 4'h5;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("full_no_ack%0d", k), {15'd0, ack1}, 16'd0);
        end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("full_grant3", outs3(), {7'd0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        cyc();
        chk("full_late_ack", {15'd0, ack1}, 16'd1);
        req1 = 1'b0;
        frame_tick = 1'b1;
        repeat (3) cyc();
        chk("full_hold_done", {15'd0, busy}, 16'd0);
        cyc();
        frame_tick = 1'b0;
        chk("full_grant5", outs3(), {7'd0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

        // hold disabled: back-to-back grants on the second DUT
        rst_pulse();
        req0 = 1'b1; data0 = 4'hA;
        cyc();
        chk("h0_ackA", {15'd0, z_ack0}, 16'd1);
        req0 = 1'b0; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("h0_grantA", outs0(), {7'd0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        req0 = 1'b1; data0 = 4'hB;
        cyc();
        chk("h0_idleB", outs0(), {7'd0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        req0 = 1'b0; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("h0_grantB", outs0(), {7'd0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        cyc();
        chk("h0_after", outs0(), {7'd0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // async reset mid-hold with slot1 full
        rst_pulse();
        req0 = 1'b1; data0 = 4'h1;
        cyc();
        req0 = 1'b0; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        req1 = 1'b1; data1 = 4'h8;
        cyc();
        req1 = 1'b0; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("ar_pre", outs3(), {7'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        #3 rstn = 1'b0;
        #1;
        chk("ar_async", outs3(), 16'h0);
        cyc();
        rstn = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("ar_no_strobe", outs3(), 16'h0);
        cyc();
        chk("ar_idle", outs3(), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_disp_arb.md
Name: vga_disp_arb

Overview:
Shares the single-digit VGA display between two requesters: the CPU config-register path (src 0) and the board debug switch path (src 1). It captures each request into a 1-deep slot with a req/ack handshake. At a frame boundary it picks one pending slot round-robin and drives num/confreg_en to the digit renderer for one cycle. It then enforces a minimum display time before the next switch, so updates never land mid-frame.

Parameters:
HOLD_FRAMES, 60, frames a granted digit stays before the next grant (60 = ~1 s at 1024x768@60); 0 disables hold
CNT_W, 8, hold counter width; HOLD_FRAMES must be < 2^CNT_W (elaboration error otherwise)

Ports:
clk_vga  in  1  pixel clock; the only clock
rstn  in  1  reset, asynchronous assert, active-low
frame_tick  in  1  one-cycle pulse at frame start from the timing generator (v_cur wrap)
req0  in  1  src 0 request; held high with data0 stable until ack0
data0  in  4  src 0 hex digit
ack0  out  1  one-cycle pulse: data0 captured
req1  in  1  src 1 request
data1  in  4  src 1 hex digit
ack1  out  1  one-cycle pulse: data1 captured
num  out  4  digit to renderer; registered, holds last granted value
confreg_en  out  1  one-cycle update strobe to renderer
cur_src  out  1  source of the digit currently shown
busy  out  1  high in EMIT or HOLD

Behaviour:
- Reset (async, rstn=0): num=0, confreg_en=0, ack0=ack1=0, cur_src=0, busy=0, both slots empty, last_grant=1 (src 0 wins the first tie), hold cnt=0, state=IDLE. Reset mid-hold or with pending slots drops everything; no ack is issued for a request that was not captured.
- Slot capture, per source, independent:
  - Capture when req && !ack && slot empty: slot<=data, full<=1, ack<=1 on the same edge.
  - ack is a pulse, cleared next edge.
  - Requester drops req after seeing ack. req still high in the ack cycle is not recaptured.
  - If the slot is full, ack is withheld and req stays pending. No overwrite.
- FSM states IDLE, EMIT, HOLD:
  - IDLE: on frame_tick with any slot full, select a source.
    - Only one full: select it.
    - Both full: select !last_grant.
    - Same edge: num<=slot, cur_src<=sel, last_grant<=sel, slot full<=0, confreg_en<=1, state<=EMIT.
    - frame_tick with no slot full: stay in IDLE, no strobe.
  - EMIT (exactly 1 cycle): confreg_en<=0.
    - If HOLD_FRAMES==0, state<=IDLE.
    - Else cnt<=HOLD_FRAMES, state<=HOLD.
    - A frame_tick seen in EMIT is ignored.
  - HOLD: each frame_tick decrements cnt. The tick that takes cnt 1->0 moves to IDLE. That tick does not also grant; the earliest next grant is the following tick. Slots keep capturing during HOLD.
- Latency: strobe is asserted the cycle after the granting frame_tick. A request arriving in IDLE is captured 1 cycle after req and displayed at the next frame_tick.
- The slot being consumed on an edge is seen as full that cycle. A concurrent req on the same source is captured on the following edge.
- busy = (state != IDLE), registered with the state.
- num is never changed except on a grant edge.

Decomposition:
- Package vga_disp_pkg holds:
  - state encoding (IDLE/EMIT/HOLD)
  - SRC_CPU=0, SRC_SW=1
  - HOLD_FRAMES default
  - digit width constant (4)
- Sub-module vga_req_slot, instantiated twice: req/ack capture, 1-deep storage, full flag, clear input from the arbiter.
- Top holds the FSM, round-robin pointer, hold counter and output registers.

Test Plan:
1. Reset, then req0=1 with data0=4'h7, then one frame_tick -> ack0 pulses 1 cycle after req. One cycle after the tick: num=7, confreg_en high for exactly 1 cycle, cur_src=0, busy=1.
2. HOLD_FRAMES=3: both slots filled (data0=2, data1=9) before tick T0 -> grant src0 (num=2) at T0. No grant at T1..T3. Grant src1 (num=9) at T4.
3. Round-robin: after item 2, refill both slots -> next grant goes to src0. Repeated refills alternate 0,1,0,1.
4. Slot full: hold req1 high with data1=5 while slot1 holds 3 -> no ack1. ack1 pulses the cycle after slot1 is consumed; next grant shows 5.
5. HOLD_FRAMES=0: req0 data=A, tick, then req0 data=B, tick -> two consecutive grants (num=A, then B), each with a 1-cycle strobe.
6. Assert rstn=0 asynchronously mid-HOLD with slot1 full -> outputs return to reset values immediately. After release, a tick with no req produces no strobe.
